ahb_fifo_slave: RTL and testbench

AHB slave (responder) that bridges the shared AHB bus to a local streaming interface through two word-wide FIFOs: AHB writes to DATA push into a TX FIFO drained by a local consumer, and AHB reads of DATA pop an RX FIFO filled by a local producer. It attaches to the bus fabric alongside the RAM slaves, on its own `hsel` line, and returns its `hready_resp`/`hresp`/`hrdata` to the bus multiplexer. Illegal accesses get the standard two-cycle AHB ERROR response.

---
 rtl/ahb_pkg.sv | 31 +++
 rtl/ahb_fifo_slave_fifo.sv | 62 ++++++
 rtl/ahb_fifo_slave.sv | 147 ++++++++++++++
 tb/tb_ahb_fifo_slave.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, register offsets and FSM state type for the FIFO slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Offsets as seen in haddr[3:2]
  localparam logic [1:0] REG_DATA   = 2'b00;
  localparam logic [1:0] REG_STATUS = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DATA = 2'b01,
    S_ERR2 = 2'b10
  } state_t;

  function automatic logic [31:0] status_word(input logic [7:0] rx_cnt,
                                              input logic [5:0] tx_cnt,
                                              input logic       rx_empty,
                                              input logic       tx_full);
    return {16'h0000, rx_cnt, tx_cnt, rx_empty, tx_full};
  endfunction

endpackage

// File: rtl/ahb_fifo_slave_fifo.sv
// Show-ahead synchronous FIFO; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign count     = count_r;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  // An empty FIFO presents zero rather than stale storage
  assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage write; contents need no reset since dout is masked while empty
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ahb_fifo_slave.sv
// AHB slave bridging a DATA/STATUS register pair to a TX and an RX word FIFO,
// with the two-cycle ERROR response for illegal or impossible accesses.
module ahb_fifo_slave
  import ahb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        hclk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hready_resp,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  output logic        rx_ready
);

  state_t      state_r;
  logic        wr_r;
  logic [1:0]  addr_r;
  logic        size_ok_r;

  logic        accept_s;
  logic        err_s;
  logic        tx_push_s;
  logic        rx_pop_s;
  logic        tx_full_s;
  logic        tx_empty_s;
  logic        rx_full_s;
  logic        rx_empty_s;
  logic [CW-1:0] tx_count_s;
  logic [CW-1:0] rx_count_s;
  logic [31:0] rx_dout_s;
  logic [31:0] status_s;
  logic        unused_s;

  assign unused_s = ^{hburst, haddr[31:4], haddr[1:0], htrans[0]};
  assign accept_s = hsel & hready & htrans[1];
  assign status_s = status_word(8'(rx_count_s), 6'(tx_count_s), rx_empty_s, tx_full_s);

  // Error decision uses only the flags as they stand, never a same-cycle local pop/push
  always_comb begin
    err_s = 1'b0;
    if (state_r == S_DATA) begin
      err_s = ~size_ok_r
            | addr_r[1]
            | ((addr_r == REG_DATA) & wr_r & tx_full_s)
            | ((addr_r == REG_DATA) & ~wr_r & rx_empty_s);
    end else begin
      err_s = 1'b0;
    end
  end

  assign tx_push_s = (state_r == S_DATA) & ~err_s & wr_r & (addr_r == REG_DATA);
  assign rx_pop_s  = (state_r == S_DATA) & ~err_s & ~wr_r & (addr_r == REG_DATA);

  // Bus response derived from state and FIFO flags only
  always_comb begin
    hready_resp = 1'b1;
    hresp       = HRESP_OKAY;
    hrdata      = 32'h0000_0000;
    case (state_r)
      S_DATA: begin
        if (err_s) begin
          hready_resp = 1'b0;
          hresp       = HRESP_ERROR;
        end else if (!wr_r) begin
          case (addr_r)
            REG_DATA:   hrdata = rx_dout_s;
            REG_STATUS: hrdata = status_s;
            default:    hrdata = 32'h0000_0000;
          endcase
        end else begin
          hrdata = 32'h0000_0000;
        end
      end
      S_ERR2: begin
        hresp = HRESP_ERROR;
      end
      default: begin
        hready_resp = 1'b1;
      end
    endcase
  end

  // Transfer FSM plus address-phase capture
  always_ff @(posedge hclk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      wr_r      <= 1'b0;
      addr_r    <= 2'b00;
      size_ok_r <= 1'b0;
    end else begin
      case (state_r)
        S_DATA:  state_r <= err_s ? S_ERR2 : (accept_s ? S_DATA : S_IDLE);
        S_IDLE,
        S_ERR2:  state_r <= accept_s ? S_DATA : S_IDLE;
        default: state_r <= S_IDLE;
      endcase
      if (accept_s && !(state_r == S_DATA && err_s)) begin
        wr_r      <= hwrite;
        addr_r    <= haddr[3:2];
        size_ok_r <= (hsize == HSIZE_WORD);
      end
    end
  end

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (hclk),
    .reset (reset),
    .push  (tx_push_s),
    .pop   (tx_ready),
    .din   (hwdata),
    .dout  (tx_data),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .count (tx_count_s)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (hclk),
    .reset (reset),
    .push  (rx_valid),
    .pop   (rx_pop_s),
    .din   (rx_data),
    .dout  (rx_dout_s),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .count (rx_count_s)
  );

  assign tx_valid = ~tx_empty_s;
  assign rx_ready = ~rx_full_s;

endmodule

// File: tb/tb_ahb_fifo_slave.sv
// Self-checking bench for ahb_fifo_slave against queue-based FIFO models.
module tb_ahb_fifo_slave;

  logic        hclk = 1'b0;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_ready;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] rd;

  always #5 hclk = ~hclk;

  // Single slave on the bus: bus-level hready is this slave's ready
  ahb_fifo_slave dut (
    .hclk(hclk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready(hready_resp), .hready_resp(hready_resp), .hresp(hresp), .hrdata(hrdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
  );

  function automatic logic [31:0] exp_status();
    return {16'h0000, 8'(rx_q.size()), 6'(tx_q.size()), (rx_q.size() == 0), (tx_q.size() == 8)};
  endfunction

  // One AHB transfer, optionally with a local pop/push during its first data cycle
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [1:0] trans, input logic [31:0] wdata,
                      input logic lpop, input logic lpush, input logic [31:0] ldata,
                      output logic [31:0] rdata);
    logic active, is_data, err, do_tx_pop, do_rx_push;
    logic [31:0] exp_rd, exp_txd;
    active  = trans[1];
    is_data = (addr[3:2] == 2'b00);
    err = active && ((size != 3'b010) || addr[3] || (is_data && wr && tx_q.size() == 8) ||
                     (is_data && !wr && rx_q.size() == 0));
    exp_rd = 32'h0;
    if (active && !wr && !err) exp_rd = is_data ? rx_q[0] : exp_status();
    exp_txd = (tx_q.size() != 0) ? tx_q[0] : 32'h0;
    @(negedge hclk);
    hsel = 1'b1; haddr = addr; hwrite = wr; hsize = size; htrans = trans;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwdata = wdata;
    tx_ready = lpop; rx_valid = lpush; rx_data = ldata;
    @(negedge hclk);
    rdata = hrdata;
    n_cmp++;
    if (hready_resp !== !err || hresp !== (err ? 2'b01 : 2'b00)) begin
      n_fail++;
      $display("FAIL resp1 addr=%h wr=%0d: got ready=%0d resp=%0d expected ready=%0d resp=%0d",
               addr, wr, hready_resp, hresp, !err, err);
    end
    if (!err) begin
      n_cmp++;
      if (hrdata !== exp_rd) begin
        n_fail++;
        $display("FAIL hrdata addr=%h: got %h expected %h", addr, hrdata, exp_rd);
      end
    end
    n_cmp++;
    if (tx_valid !== (tx_q.size() != 0) || tx_data !== exp_txd || rx_ready !== (rx_q.size() < 8)) begin
      n_fail++;
      $display("FAIL local: got tx_valid=%0d tx_data=%h rx_ready=%0d expected %0d %h %0d",
               tx_valid, tx_data, rx_ready, tx_q.size() != 0, exp_txd, rx_q.size() < 8);
    end
    do_tx_pop  = lpop && tx_q.size() != 0;
    do_rx_push = lpush && rx_q.size() < 8;
    @(posedge hclk);
    if (do_tx_pop) void'(tx_q.pop_front());
    if (active && !err && wr && is_data) tx_q.push_back(wdata);
    if (active && !err && !wr && is_data) void'(rx_q.pop_front());
    if (do_rx_push) rx_q.push_back(ldata);
    #1;
    tx_ready = 1'b0; rx_valid = 1'b0;
    if (err) begin
      @(negedge hclk);
      n_cmp++;
      if (hready_resp !== 1'b1 || hresp !== 2'b01) begin
        n_fail++;
        $display("FAIL resp2 addr=%h: got ready=%0d resp=%0d expected ready=1 resp=1",
                 addr, hready_resp, hresp);
      end
      @(posedge hclk); #1;
    end
  endtask

  // One idle bus cycle with local handshakes only
  task automatic local_cycle(input logic lpop, input logic lpush, input logic [31:0] ldata);
    logic [31:0] exp_txd;
    logic do_pop, do_push;
    exp_txd = (tx_q.size() != 0) ? tx_q[0] : 32'h0;
    @(negedge hclk);
    tx_ready = lpop; rx_valid = lpush; rx_data = ldata;
    #1;
    n_cmp++;
    if (tx_valid !== (tx_q.size() != 0) || tx_data !== exp_txd || rx_ready !== (rx_q.size() < 8)) begin
      n_fail++;
      $display("FAIL local_cycle: got tx_valid=%0d tx_data=%h rx_ready=%0d expected %0d %h %0d",
               tx_valid, tx_data, rx_ready, tx_q.size() != 0, exp_txd, rx_q.size() < 8);
    end
    do_pop  = lpop && tx_q.size() != 0;
    do_push = lpush && rx_q.size() < 8;
    @(posedge hclk);
    if (do_pop) void'(tx_q.pop_front());
    if (do_push) rx_q.push_back(ldata);
    #1;
    tx_ready = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hburst = 3'b000; hwdata = 32'h0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 32'h0;
    repeat (3) @(posedge hclk);
    #1 reset = 1'b0;
    tx_q.delete(); rx_q.delete();
    @(negedge hclk);
    n_cmp++;
    if (hready_resp !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0 ||
        tx_valid !== 1'b0 || tx_data !== 32'h0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%0d resp=%0d hrdata=%h tx_valid=%0d tx_data=%h rx_ready=%0d expected 1 0 0 0 0 1",
               hready_resp, hresp, hrdata, tx_valid, tx_data, rx_ready);
    end
  endtask

  task automatic test_basic_writes();
    xfer(1'b1, 32'h0, 3'b010, 2'b10, 32'hA1, 1'b0, 1'b0, 32'h0, rd);
    xfer(1'b1, 32'h0, 3'b010, 2'b10, 32'hA2, 1'b0, 1'b0, 32'h0, rd);
    xfer(1'b1, 32'h0, 3'b010, 2'b10, 32'hA3, 1'b0, 1'b0, 32'h0, rd);
    @(negedge hclk);
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 32'hA1) begin
      n_fail++;
      $display("FAIL tx_head: got valid=%0d data=%h expected 1 000000a1", tx_valid, tx_data);
    end
    xfer(1'b0, 32'h4, 3'b010, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0, rd);
    n_cmp++;
    if (rd[7:2] !== 6'd3) begin
      n_fail++;
      $display("FAIL status_tx_count: got %0d expected 3", rd[7:2]);
    end
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < 5; i++)
      xfer(1'b1, 32'h0, 3'b010, 2'b10, 32'hB0 + i, 1'b0, 1'b0, 32'h0, rd);
    xfer(1'b1, 32'h0, 3'b010, 2'b10, 32'hFF, 1'b0, 1'b0, 32'h0, rd);
    xfer(1'b0, 32'h4, 3'b010, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0, rd);
    n_cmp++;
    if (rd[7:2] !== 6'd8 || rd[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_count: got count=%0d full=%0d expected 8 1", rd[7:2], rd[0]);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (tx_data === 32'hFF) begin
        n_fail++;
        $display("FAIL tx_no_ff: got %h expected not 000000ff", tx_data);
      end
      local_cycle(1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic test_rx();
    xfer(1'b0, 32'h0, 3'b010, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0, rd);
    local_cycle(1'b0, 1'b1, 32'h55);
    xfer(1'b0, 32'h0, 3'b010, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h55) begin
      n_fail++;
      $display("FAIL rx_read: got %h expected 00000055", rd);
    end
    xfer(1'b0, 32'h4, 3'b010, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h2) begin
      n_fail++;
      $display("FAIL status_rx_empty: got %h expected 00000002", rd);
    end
  endtask

  task automatic test_illegal();
    xfer(1'b1, 32'h0, 3'b001, 2'b10, 32'h77, 1'b0, 1'b0, 32'h0, rd);
    xfer(1'b0, 32'h8, 3'b010, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0, rd);
    xfer(1'b1, 32'hC, 3'b010, 2'b10, 32'h66, 1'b0, 1'b0, 32'h0, rd);
    xfer(1'b1, 32'h0, 3'b010, 2'b00, 32'h44, 1'b0, 1'b0, 32'h0, rd);
    xfer(1'b1, 32'h0, 3'b010, 2'b01, 32'h45, 1'b0, 1'b0, 32'h0, rd);
    xfer(1'b1, 32'h4, 3'b010, 2'b10, 32'h33, 1'b0, 1'b0, 32'h0, rd);
    xfer(1'b0, 32'h4, 3'b010, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h2) begin
      n_fail++;
      $display("FAIL illegal_no_effect: got %h expected 00000002", rd);
    end
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 32'h0, 3'b010, 2'b10, 32'hC0 + i, 1'b0, 1'b0, 32'h0, rd);
    xfer(1'b1, 32'h0, 3'b010, 2'b10, 32'hC4, 1'b1, 1'b0, 32'h0, rd);
    xfer(1'b0, 32'h4, 3'b010, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h12) begin
      n_fail++;
      $display("FAIL concurrent_count: got %h expected 00000012", rd);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (tx_data !== 32'hC1 + i) begin
        n_fail++;
        $display("FAIL concurrent_order: got %h expected %h", tx_data, 32'hC1 + i);
      end
      local_cycle(1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++)
      xfer(1'b1, 32'h0, 3'b010, 2'b10, 32'hD0 + i, 1'b0, 1'b0, 32'h0, rd);
    @(negedge hclk);
    hsel = 1'b1; haddr = 32'h0; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
    @(posedge hclk); #1;
    htrans = 2'b11; hwdata = 32'hD7;
    @(negedge hclk);
    n_cmp++;
    if (hready_resp !== 1'b1 || hresp !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_beat1: got ready=%0d resp=%0d expected 1 0", hready_resp, hresp);
    end
    @(posedge hclk);
    tx_q.push_back(32'hD7);
    #1 hsel = 1'b0; htrans = 2'b00; hwdata = 32'hEE;
    @(negedge hclk);
    n_cmp++;
    if (hready_resp !== 1'b0 || hresp !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_beat2_c1: got ready=%0d resp=%0d expected 0 1", hready_resp, hresp);
    end
    @(posedge hclk); #1;
    @(negedge hclk);
    n_cmp++;
    if (hready_resp !== 1'b1 || hresp !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_beat2_c2: got ready=%0d resp=%0d expected 1 1", hready_resp, hresp);
    end
    @(posedge hclk); #1;
    xfer(1'b0, 32'h4, 3'b010, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0, rd);
    for (int i = 0; i < 8; i++) local_cycle(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    int op;
    logic lpop, lpush;
    for (int i = 0; i < 250; i++) begin
      op    = int'($urandom_range(0, 9));
      lpop  = ($urandom_range(0, 3) == 0);
      lpush = ($urandom_range(0, 1) == 0);
      case (op)
        0, 1, 2: xfer(1'b1, 32'h0, 3'b010, 2'b10 | 2'($urandom_range(0, 1)), $urandom, lpop, lpush, $urandom, rd);
        3, 4:    xfer(1'b0, 32'h0, 3'b010, 2'b10, 32'h0, lpop, lpush, $urandom, rd);
        5:       xfer(1'b0, 32'h4, 3'b010, 2'b11, 32'h0, lpop, lpush, $urandom, rd);
        6:       xfer(1'b1, 32'h4, 3'b010, 2'b10, $urandom, lpop, lpush, $urandom, rd);
        7:       xfer($urandom_range(0, 1) == 1, 32'h0, 3'($urandom_range(0, 1)), 2'b10, $urandom, lpop, lpush, $urandom, rd);
        8:       xfer(1'b1, {28'h0, 2'($urandom_range(2, 3)), 2'b00}, 3'b010, 2'b10, $urandom, lpop, lpush, $urandom, rd);
        default: local_cycle(lpop, lpush, $urandom);
      endcase
    end
  endtask

  task automatic test_reset_err2();
    xfer(1'b1, 32'h0, 3'b010, 2'b10, 32'h0, 1'b1, 1'b1, 32'h99, rd);
    local_cycle(1'b0, 1'b1, 32'h9A);
    if (tx_q.size() == 0) xfer(1'b1, 32'h0, 3'b010, 2'b10, 32'h98, 1'b0, 1'b0, 32'h0, rd);
    @(negedge hclk);
    hsel = 1'b1; haddr = 32'h8; hwrite = 1'b0; hsize = 3'b010; htrans = 2'b10;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(posedge hclk); #1;
    @(negedge hclk);
    n_cmp++;
    if (hready_resp !== 1'b1 || hresp !== 2'b01 || tx_valid !== 1'b1 || rx_ready === 1'bx) begin
      n_fail++;
      $display("FAIL err2_state: got ready=%0d resp=%0d tx_valid=%0d expected 1 1 1", hready_resp, hresp, tx_valid);
    end
    reset = 1'b1;
    @(posedge hclk); #1;
    reset = 1'b0;
    tx_q.delete(); rx_q.delete();
    @(negedge hclk);
    n_cmp++;
    if (hready_resp !== 1'b1 || hresp !== 2'b00 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_err2: got ready=%0d resp=%0d tx_valid=%0d rx_ready=%0d expected 1 0 0 1",
               hready_resp, hresp, tx_valid, rx_ready);
    end
    xfer(1'b0, 32'h4, 3'b010, 2'b10, 32'h0, 1'b0, 1'b0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h2) begin
      n_fail++;
      $display("FAIL status_after_reset: got %h expected 00000002", rd);
    end
  endtask

  initial begin
    test_reset();
    test_basic_writes();
    test_tx_full();
    test_rx();
    test_illegal();
    test_concurrent();
    test_back_to_back();
    test_random();
    test_reset_err2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
